fetch_buffer: RTL and testbench
===============================

Name: fetch_buffer

Overview:
- Fetch-side queue directly downstream of the PC address generator.
- Issues each PCF to a synchronous 1-cycle-latency instruction memory and captures the returned word with its PC and PC+4 in a small FIFO.
- Presents the FIFO head to the IF/ID boundary and drives StallF back to the address generator, so decode stalls never drop or duplicate instructions.
- FlushD (taken branch/jump, PCSrcE) discards all buffered and in-flight fetches.

Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- XLEN, 32: instruction/PC width; fixed at 32.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset; one clock, asynchronous assert, active-low, synchronous-release handled externally.
- PCF  in  32  current fetch PC from the address generator.
- StallF  out  1  hold PC in the address generator.
- imem_req  out  1  instruction memory read strobe.
- imem_addr  out  32  read address; equals PCF.
- imem_rdata  in  32  read data, valid exactly one cycle after an accepted imem_req.
- StallD  in  1  decode cannot accept this cycle.
- FlushD  in  1  discard all fetched/in-flight instructions at this edge.
- ValidD  out  1  head entry valid.
- InstrD  out  32  head instruction.
- PCD  out  32  head PC.
- PCPlus4D  out  32  head PC+4.

Behaviour:
- State:
  - FIFO storage of {PC, instr}.
  - wr_ptr, rd_ptr: log2(DEPTH) bits, natural wrap.
  - count: log2(DEPTH)+1 bits.
  - inflight_v, inflight_pc.
- Reset (rst=0, asynchronous): count=0, pointers=0, inflight_v=0.
  - Outputs immediately: ValidD=0, InstrD=NOP (32'h00000013), PCD=0, PCPlus4D=0.
  - StallF=0, imem_req=0 while in reset.
- StallF = (count + inflight_v >= DEPTH). Registered terms only; no combinational path from StallD or FlushD.
- imem_req = !StallF out of reset; imem_addr = PCF always.
- Issue edge, with imem_req=1 and FlushD=0: inflight_v←1, inflight_pc←PCF. Otherwise inflight_v←0.
- Capture edge, with inflight_v=1 and FlushD=0: write {inflight_pc, imem_rdata} at wr_ptr; wr_ptr++.
- Pop: ValidD && !StallD && !FlushD advances rd_ptr.
- count update: count += push − pop; simultaneous push and pop leaves count unchanged.
- Outputs:
  - ValidD = (count != 0).
  - InstrD/PCD come from the head entry; PCPlus4D = PCD + 32'd4, modulo 2^32 (0xFFFFFFFC → 0).
  - When ValidD=0: InstrD=NOP, PCD=0, PCPlus4D=0.
- Latency: PCF presented in cycle t → InstrD valid in cycle t+2 (queue empty, no stall). Steady throughput is 1 instruction/cycle.
- FlushD=1 at an edge overrides push and pop: count←0, rd_ptr=wr_ptr←0, inflight_v←0.
  - The response arriving the following cycle is ignored.
  - A request issued in the flush cycle is also dropped.
  - The address generator loads PCTargetE at the same edge; the first target instruction appears at ValidD 2 cycles after the flush edge.
- Full: push with count==DEPTH and no pop is impossible by the StallF rule. An assertion flags it in simulation.
- Empty: pop with count==0 cannot occur (ValidD=0).
- StallD while empty has no effect.

Optional Feature:
- FETCH_BYPASS_EN defined, queue empty, inflight_v=1:
  - Head outputs come from {inflight_pc, imem_rdata}, with ValidD=1 (latency 1 cycle).
  - If popped in that cycle (StallD=0), the entry is not written.
  - If not popped, it is written normally.
  - FlushD behaves identically.
  - StallF formula unchanged.
- Not defined: no bypass; latency always 2 cycles; head driven only from FIFO storage.

Decomposition:
- Shared package holds:
  - XLEN = 32.
  - RV_NOP = 32'h00000013.
  - FETCH_DEPTH_DEF = 4.
  - A typedef/struct for the fetch entry {pc, instr}, reused by the IF/ID register.
- One natural sub-module: fetch_fifo.
  - Generic synchronous FIFO with synchronous clear, async active-low reset, count output, width and depth parameters.
  - fetch_buffer adds in-flight tracking, StallF generation and output muxing.

Test Plan:
- Reset release, StallD=0, memory returning instr = 0xA000_0000|addr:
  - PCD sequence 0,4,8,… with InstrD matching from cycle 2.
  - PCPlus4D = PCD+4.
  - No bubbles.
- StallD=1 for 8 cycles (DEPTH=4):
  - StallF rises once count+inflight_v=4; PCF holds.
  - On release, PCD 0,4,8,C,10 emerge in order with no loss or duplicate.
- Queue full, then FlushD=1 with PCF←0x100 at that edge:
  - Next cycle ValidD=0, StallF=0.
  - Stale in-flight word ignored.
  - PCD=0x100 valid 2 cycles after the flush edge.
- Alternating StallD at count=DEPTH−1: simultaneous push/pop keeps count constant; order preserved across pointer wrap.
- rst driven low mid-stream between clock edges:
  - ValidD=0 and InstrD=NOP immediately, without a clock edge.
  - After release, fetch restarts at PCD=0.
- FETCH_BYPASS_EN defined: from empty, PCF=0x40 yields ValidD/PCD=0x40 in the next cycle (latency 1).
  - With StallD=1 in that cycle, the entry is retained and reappears next cycle.

Source files
------------

// File: rtl/fetch_buffer_pkg.sv
// fetch_buffer_pkg: shared fetch widths, NOP encoding and the {pc, instr} entry type
package fetch_buffer_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;
  localparam int FETCH_DEPTH_DEF = 4;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with synchronous clear, async active-low reset and occupancy count
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    wr_ptr_d = clr ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = clr ? '0 : rd_ptr_q + AW'(pop);
    count_d  = clr ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  always_ff @(posedge clk)
    if (push && !clr) mem_q[wr_ptr_q] <= din;
  // Upstream flow control must never let a push land on a full queue
  always_ff @(posedge clk)
    if (rst && push && !pop && !clr) assert (count_q != CW'(DEPTH));
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: fetch queue between the PC generator and decode, tracking one in-flight imem read.
// Define FETCH_BYPASS_EN to forward the returning word to decode when the queue is empty.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PCF,
  output logic            StallF,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            StallD,
  input  logic            FlushD,
  output logic            ValidD,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic            inflight_v_q, inflight_v_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  fetch_entry_t    fifo_head, inflight_entry, head;
  logic            bypass, pop, fifo_push, fifo_pop;
  // Stall from registered occupancy only, so decode-side inputs never reach StallF
  assign occupancy      = {1'b0, count} + {{CW{1'b0}}, inflight_v_q};
  assign StallF         = occupancy >= (CW+1)'(DEPTH);
  assign imem_req       = rst && !StallF;
  assign imem_addr      = PCF;
  assign inflight_entry = '{pc: inflight_pc_q, instr: imem_rdata};
`ifdef FETCH_BYPASS_EN
  assign bypass = inflight_v_q && count == '0;
`else
  assign bypass = 1'b0;
`endif
  assign head      = bypass ? inflight_entry : fifo_head;
  assign ValidD    = count != '0 || bypass;
  assign pop       = ValidD && !StallD && !FlushD;
  assign fifo_pop  = pop && !bypass;
  assign fifo_push = inflight_v_q && !FlushD && !(bypass && pop);
  assign InstrD    = ValidD ? head.instr : RV_NOP;
  assign PCD       = ValidD ? head.pc : '0;
  assign PCPlus4D  = ValidD ? head.pc + 32'd4 : '0;
  always_comb begin
    inflight_v_d  = imem_req && !FlushD;
    inflight_pc_d = imem_req ? PCF : inflight_pc_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      inflight_v_q  <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      inflight_v_q  <= inflight_v_d;
      inflight_pc_q <= inflight_pc_d;
    end
  fetch_fifo #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (FlushD),
    .push  (fifo_push),
    .din   (inflight_entry),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .count (count)
  );
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: scoreboard bench for fetch_buffer; FETCH_BYPASS_EN switches to bypass latencies
module tb_fetch_buffer;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif
  logic        clk = 1'b0;
  logic        rst, StallD, FlushD, StallF, imem_req, ValidD;
  logic [31:0] PCF, imem_addr, imem_rdata, InstrD, PCD, PCPlus4D, target, mon_e;
  int          tests = 0, fails = 0;
  logic [31:0] exp_q[$];

  fetch_buffer #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .PCF        (PCF),
    .StallF     (StallF),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .ValidD     (ValidD),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D)
  );

  always #5 clk = ~clk;

  // Address generator: holds on StallF, redirects on FlushD
  always @(posedge clk or negedge rst)
    if (!rst) PCF <= 32'h0;
    else if (FlushD) PCF <= target;
    else if (!StallF) PCF <= PCF + 32'd4;

  always @(posedge clk) imem_rdata <= 32'hA000_0000 | imem_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (rst === 1'b1 && ValidD && !StallD && !FlushD) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL order: unexpected PCD %h with no expected entry", PCD);
      end else begin
        mon_e = exp_q.pop_front();
        chk("order_pc", PCD, mon_e);
        chk("order_instr", InstrD, 32'hA000_0000 | mon_e);
        chk("order_pc4", PCPlus4D, mon_e + 32'd4);
      end
    end

  initial begin
    rst = 1'b0; StallD = 1'b0; FlushD = 1'b0; target = 32'h0;
    #3;
    chk("rst_valid", ValidD, 0);
    chk("rst_instr", InstrD, NOP);
    chk("rst_pcd", PCD, 0);
    chk("rst_pc4", PCPlus4D, 0);
    chk("rst_stallf", StallF, 0);
    chk("rst_req", imem_req, 0);
    tick(); tick();
    for (int i = 0; i < 64; i++) exp_q.push_back(32'(i * 4));
    rst = 1'b1;
    #1;
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 0);
    tick();
    chk("lat_valid1", ValidD, 1'(BYP));
    tick();
    chk("lat_valid2", ValidD, 1);
    chk("lat_pcd", PCD, 32'(4 * BYP));
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("no_bubble", ValidD, 1);
    end
    tick();
    StallD = 1'b1;
    chk("stallf_pre", StallF, 0);
    repeat (1 + BYP) tick();
    chk("stallf_low", StallF, 0);
    tick();
    chk("stallf_rise", StallF, 1);
    repeat (5 - BYP) tick();
    chk("stall_hold", StallF, 1);
    chk("pcf_hold", PCF, 32'h30 + 32'(4 * BYP));
    chk("stall_head_v", ValidD, 1);
    chk("stall_head_pc", PCD, 32'h20 + 32'(4 * BYP));
    tick();
    StallD = 1'b0;
    repeat (6) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      StallD = (i % 2) == 0;
    end
    tick();
    StallD = 1'b1;
    repeat (8) tick();
    chk("full_stallf", StallF, 1);
    chk("full_req", imem_req, 0);
    StallD = 1'b0;
    tick();
    StallD = 1'b1;
    chk("refill_req", imem_req, 1);
    tick();
    chk("inflight_stallf", StallF, 1);
    chk("flush_head", PCD, exp_q[0]);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h100 + 32'(i * 4));
    FlushD = 1'b1;
    target = 32'h100;
    tick();
    FlushD = 1'b0;
    StallD = 1'b0;
    chk("flush_valid", ValidD, 0);
    chk("flush_stallf", StallF, 0);
    chk("flush_pcf", PCF, 32'h100);
    tick();
`ifdef FETCH_BYPASS_EN
    chk("flush_tgt_v", ValidD, 1);
    chk("flush_tgt_pc", PCD, 32'h100);
`else
    chk("flush_gap_v", ValidD, 0);
    tick();
    chk("flush_tgt_v", ValidD, 1);
    chk("flush_tgt_pc", PCD, 32'h100);
`endif
    repeat (5) tick();
    #3;
    rst = 1'b0;
    #1;
    chk("async_valid", ValidD, 0);
    chk("async_instr", InstrD, NOP);
    chk("async_pcd", PCD, 0);
    chk("async_pc4", PCPlus4D, 0);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(i * 4));
    tick(); tick();
    rst = 1'b1;
    tick();
    StallD = 1'b1;
`ifdef FETCH_BYPASS_EN
    chk("byp_valid", ValidD, 1);
    chk("byp_pc", PCD, 0);
`else
    chk("restart_empty", ValidD, 0);
`endif
    tick();
    chk("restart_valid", ValidD, 1);
    chk("restart_pc", PCD, 0);
    StallD = 1'b0;
    repeat (6) tick();
    StallD = 1'b1;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
